ddr3_lane_dq_delay_trainer: RTL and testbench

Per-lane DQ read-delay trainer for the DDR3 PHY read-training path. It drives the lane IOD's dynamic delay-line controls and eye-monitor clear, and consumes the IOD's deserialised RX data, eye-monitor early/late flags and out-of-range flag. It sweeps the input delay upward from the loaded tap and finds the first contiguous passing window against a known read pattern. It then parks the delay line at the window centre and reports the result to the training sequencer.

---
 rtl/ddr3_lane_dq_delay_trainer.sv | 223 ++++++++++++++++++++++
 tb/tb_ddr3_lane_dq_delay_trainer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_lane_dq_delay_trainer.sv
// Per-lane DQ read-delay trainer: sweeps the IOD input delay upward from the
// loaded tap, finds the first contiguous passing window against the expected
// read pattern, then parks the delay line at the window centre.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for TRAIN_START after reset
// S_LOAD   | reload static delay, tap counter becomes 0
// S_CLEAR  | clear the sticky eye-monitor flags
// S_SETTLE | let the delay line and flags settle
// S_SAMPLE | compare RX data and watch early/late for SAMPLE_CYC cycles
// S_EVAL   | update window, decide step / centre / fail
// S_STEP   | one increment move plus one gap cycle
// S_CENTER | alternating gap/decrement-move cycles until tap == centre
// S_DONE   | result valid, TRAIN_DONE high
// S_FAIL   | no passing tap found, TRAIN_ERR high
module ddr3_lane_dq_delay_trainer #(
   parameter int MAX_TAPS   = 128,
   parameter int SETTLE_CYC = 8,
   parameter int SAMPLE_CYC = 16
) (
   input  logic       FAB_CLK,
   input  logic       ARST_N,
   input  logic       TRAIN_START,
   input  logic [7:0] EXPECTED_PATTERN,
   input  logic [7:0] RX_DATA_0,
   input  logic       EYE_MONITOR_EARLY_0,
   input  logic       EYE_MONITOR_LATE_0,
   input  logic       DELAY_LINE_OUT_OF_RANGE_0,
   output logic       DELAY_LINE_LOAD_0,
   output logic       DELAY_LINE_MOVE_0,
   output logic       DELAY_LINE_DIRECTION_0,
   output logic       EYE_MONITOR_CLEAR_FLAGS_0,
   output logic       TRAIN_BUSY,
   output logic       TRAIN_DONE,
   output logic       TRAIN_ERR,
   output logic [7:0] CENTER_TAP,
   output logic [7:0] WINDOW_WIDTH
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE,
      S_EVAL, S_STEP, S_CENTER, S_DONE, S_FAIL
   } state_t;

   localparam logic [7:0] LAST_TAP  = 8'(MAX_TAPS - 1);
   localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] SAMPLE_LD = 8'(SAMPLE_CYC - 1);

   state_t     state_q, state_d;
   logic [7:0] tap_q, tap_d;
   logic [7:0] first_q, first_d;
   logic [7:0] last_q, last_d;
   logic       in_window_q, in_window_d;
   logic [7:0] cnt_q, cnt_d;
   logic       fail_q, fail_d;
   logic       phase_q, phase_d;
   logic [7:0] center_q, center_d;
   logic [7:0] width_q, width_d;

   logic [8:0] win_sum;
   logic [7:0] center_calc;
   logic [7:0] width_calc;
   logic       sample_bad;
   logic       pass_now;
   logic       sweep_end;

   // Window arithmetic and per-cycle sample verdict
   always_comb begin
      win_sum     = {1'b0, first_q} + {1'b0, last_q};
      center_calc = win_sum[8:1];
      width_calc  = last_q - first_q + 8'd1;
      sample_bad  = (RX_DATA_0 != EXPECTED_PATTERN) | EYE_MONITOR_EARLY_0 | EYE_MONITOR_LATE_0;
      pass_now    = ~fail_q;
      sweep_end   = (tap_q == LAST_TAP) | DELAY_LINE_OUT_OF_RANGE_0;
   end

   // State and datapath registers
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         state_q     <= S_IDLE;
         tap_q       <= '0;
         first_q     <= '0;
         last_q      <= '0;
         in_window_q <= 1'b0;
         cnt_q       <= '0;
         fail_q      <= 1'b0;
         phase_q     <= 1'b0;
         center_q    <= '0;
         width_q     <= '0;
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         first_q     <= first_d;
         last_q      <= last_d;
         in_window_q <= in_window_d;
         cnt_q       <= cnt_d;
         fail_q      <= fail_d;
         phase_q     <= phase_d;
         center_q    <= center_d;
         width_q     <= width_d;
      end
   end

   // Next-state logic and Moore outputs
   always_comb begin
      state_d     = state_q;
      tap_d       = tap_q;
      first_d     = first_q;
      last_d      = last_q;
      in_window_d = in_window_q;
      cnt_d       = cnt_q;
      fail_d      = fail_q;
      phase_d     = phase_q;
      center_d    = center_q;
      width_d     = width_q;

      DELAY_LINE_LOAD_0         = 1'b0;
      DELAY_LINE_MOVE_0         = 1'b0;
      DELAY_LINE_DIRECTION_0    = 1'b0;
      EYE_MONITOR_CLEAR_FLAGS_0 = 1'b0;
      TRAIN_BUSY                = 1'b1;
      TRAIN_DONE                = 1'b0;
      TRAIN_ERR                 = 1'b0;

      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            TRAIN_BUSY = 1'b0;
            TRAIN_DONE = (state_q == S_DONE);
            TRAIN_ERR  = (state_q == S_FAIL);
            if (TRAIN_START) begin
               state_d     = S_LOAD;
               tap_d       = '0;
               first_d     = '0;
               last_d      = '0;
               in_window_d = 1'b0;
               center_d    = '0;
               width_d     = '0;
            end
         end
         S_LOAD: begin
            DELAY_LINE_LOAD_0 = 1'b1;
            tap_d             = '0;
            state_d           = S_CLEAR;
         end
         S_CLEAR: begin
            EYE_MONITOR_CLEAR_FLAGS_0 = 1'b1;
            cnt_d                     = SETTLE_LD;
            state_d                   = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == 8'd0) begin
               cnt_d   = SAMPLE_LD;
               fail_d  = 1'b0;
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_SAMPLE: begin
            fail_d = fail_q | sample_bad;
            if (cnt_q == 8'd0) begin
               state_d = S_EVAL;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_EVAL: begin
            // Direction is raised here so it is stable the cycle before an increment move
            DELAY_LINE_DIRECTION_0 = 1'b1;
            phase_d                = 1'b0;
            if (pass_now) begin
               if (!in_window_q) begin
                  first_d = tap_q;
               end
               in_window_d = 1'b1;
               last_d      = tap_q;
            end
            if (!pass_now && in_window_q) begin
               state_d = S_CENTER;
            end else if (sweep_end) begin
               state_d = (in_window_q | pass_now) ? S_CENTER : S_FAIL;
            end else begin
               state_d = S_STEP;
            end
         end
         S_STEP: begin
            DELAY_LINE_DIRECTION_0 = 1'b1;
            if (!phase_q) begin
               DELAY_LINE_MOVE_0 = 1'b1;
               tap_d             = tap_q + 8'd1;
               phase_d           = 1'b1;
            end else begin
               phase_d = 1'b0;
               state_d = S_CLEAR;
            end
         end
         S_CENTER: begin
            // Gap cycle first so direction is low before the first decrement
            if (!phase_q) begin
               if (tap_q == center_calc) begin
                  center_d = center_calc;
                  width_d  = width_calc;
                  state_d  = S_DONE;
               end else begin
                  phase_d = 1'b1;
               end
            end else begin
               DELAY_LINE_MOVE_0 = 1'b1;
               tap_d             = tap_q - 8'd1;
               phase_d           = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign CENTER_TAP   = center_q;
   assign WINDOW_WIDTH = width_q;

endmodule

// File: tb/tb_ddr3_lane_dq_delay_trainer.sv
// Bench for the DQ delay trainer: an IOD model that tracks the delay tap and
// answers with pattern data, plus a table of sweep scenarios.
module tb_ddr3_lane_dq_delay_trainer;

   logic       FAB_CLK = 1'b0;
   logic       ARST_N;
   logic       TRAIN_START;
   logic [7:0] EXPECTED_PATTERN;
   logic [7:0] RX_DATA_0;
   logic       EYE_MONITOR_EARLY_0;
   logic       EYE_MONITOR_LATE_0;
   logic       DELAY_LINE_OUT_OF_RANGE_0;
   logic       DELAY_LINE_LOAD_0;
   logic       DELAY_LINE_MOVE_0;
   logic       DELAY_LINE_DIRECTION_0;
   logic       EYE_MONITOR_CLEAR_FLAGS_0;
   logic       TRAIN_BUSY;
   logic       TRAIN_DONE;
   logic       TRAIN_ERR;
   logic [7:0] CENTER_TAP;
   logic [7:0] WINDOW_WIDTH;

   ddr3_lane_dq_delay_trainer dut (
      .FAB_CLK                   (FAB_CLK),
      .ARST_N                    (ARST_N),
      .TRAIN_START               (TRAIN_START),
      .EXPECTED_PATTERN          (EXPECTED_PATTERN),
      .RX_DATA_0                 (RX_DATA_0),
      .EYE_MONITOR_EARLY_0       (EYE_MONITOR_EARLY_0),
      .EYE_MONITOR_LATE_0        (EYE_MONITOR_LATE_0),
      .DELAY_LINE_OUT_OF_RANGE_0 (DELAY_LINE_OUT_OF_RANGE_0),
      .DELAY_LINE_LOAD_0         (DELAY_LINE_LOAD_0),
      .DELAY_LINE_MOVE_0         (DELAY_LINE_MOVE_0),
      .DELAY_LINE_DIRECTION_0    (DELAY_LINE_DIRECTION_0),
      .EYE_MONITOR_CLEAR_FLAGS_0 (EYE_MONITOR_CLEAR_FLAGS_0),
      .TRAIN_BUSY                (TRAIN_BUSY),
      .TRAIN_DONE                (TRAIN_DONE),
      .TRAIN_ERR                 (TRAIN_ERR),
      .CENTER_TAP                (CENTER_TAP),
      .WINDOW_WIDTH              (WINDOW_WIDTH)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   typedef struct {
      int lo1, hi1, lo2, hi2;
      int late_tap, oor_tap;
      int exp_done, exp_err, exp_center, exp_width;
      int exp_incs, exp_decs, exp_tap;
   } vec_t;

   vec_t vecs[8];

   int checks = 0;
   int errors = 0;

   // scenario knobs read by the IOD model
   int cur_lo1 = 999, cur_hi1 = -1, cur_lo2 = 999, cur_hi2 = -1;
   int cur_late = 999, cur_oor = 999;

   // IOD model state and pulse statistics
   int model_tap = 0;
   int clr_cnt   = 0;
   int n_incs = 0, n_decs = 0, n_loads = 0, n_viol = 0;
   logic prev_move = 1'b0, prev_dir = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // IOD model: follows LOAD/MOVE, checks pulse protocol, drives RX data and flags
   always @(negedge FAB_CLK) begin
      if (!ARST_N) begin
         prev_move = 1'b0;
         prev_dir  = 1'b0;
      end else begin
         if (int'(DELAY_LINE_LOAD_0) + int'(DELAY_LINE_MOVE_0) + int'(EYE_MONITOR_CLEAR_FLAGS_0) > 1) begin
            n_viol++;
            $display("FAIL pulse_overlap at %0t: load %b move %b clear %b", $time,
                     DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, EYE_MONITOR_CLEAR_FLAGS_0);
         end
         if (DELAY_LINE_MOVE_0 && prev_move) begin
            n_viol++;
            $display("FAIL move_back_to_back at %0t: move high two cycles, expected gap", $time);
         end
         if (DELAY_LINE_MOVE_0 && (DELAY_LINE_DIRECTION_0 != prev_dir)) begin
            n_viol++;
            $display("FAIL dir_setup at %0t: dir %b prev %b, expected equal", $time,
                     DELAY_LINE_DIRECTION_0, prev_dir);
         end
         if (DELAY_LINE_LOAD_0) begin
            model_tap = 0;
            n_loads++;
         end
         if (DELAY_LINE_MOVE_0) begin
            if (DELAY_LINE_DIRECTION_0) begin
               model_tap++;
               n_incs++;
            end else begin
               model_tap--;
               n_decs++;
            end
         end
         if (EYE_MONITOR_CLEAR_FLAGS_0) clr_cnt = 0;
         else                           clr_cnt++;
         prev_move = DELAY_LINE_MOVE_0;
         prev_dir  = DELAY_LINE_DIRECTION_0;
      end
      if ((model_tap >= cur_lo1 && model_tap <= cur_hi1) ||
          (model_tap >= cur_lo2 && model_tap <= cur_hi2))
         RX_DATA_0 = EXPECTED_PATTERN;
      else
         RX_DATA_0 = EXPECTED_PATTERN ^ 8'hA5;
      EYE_MONITOR_EARLY_0       = 1'b0;
      EYE_MONITOR_LATE_0        = (model_tap == cur_late) && (clr_cnt == 12);
      DELAY_LINE_OUT_OF_RANGE_0 = (model_tap >= cur_oor);
   end

   task automatic pulse_start();
      TRAIN_START = 1'b1;
      @(negedge FAB_CLK);
      TRAIN_START = 1'b0;
   endtask

   task automatic wait_end(input string name);
      int n;
      n = 0;
      while (!(TRAIN_DONE || TRAIN_ERR) && n < 20000) begin
         @(negedge FAB_CLK);
         n++;
      end
      if (!(TRAIN_DONE || TRAIN_ERR)) chk({name, "_timeout"}, 1, 0);
   endtask

   task automatic set_case(input vec_t v);
      cur_lo1  = v.lo1;
      cur_hi1  = v.hi1;
      cur_lo2  = v.lo2;
      cur_hi2  = v.hi2;
      cur_late = v.late_tap;
      cur_oor  = v.oor_tap;
   endtask

   function automatic int outs_vec();
      return int'({DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0,
                   EYE_MONITOR_CLEAR_FLAGS_0, TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR,
                   CENTER_TAP, WINDOW_WIDTH});
   endfunction

   initial begin
      int inc0, dec0, ld0, vi0, n, last_mv;

      //           lo1 hi1  lo2 hi2 late oor  dn er ctr wid incs decs tap
      vecs[0] = '{ 20, 40, 999, -1, 999, 999, 1, 0,  30, 21,  41, 11,  30};
      vecs[1] = '{999, -1, 999, -1, 999, 999, 0, 1,   0,  0, 127,  0, 127};
      vecs[2] = '{  5,  9,  50, 60, 999, 999, 1, 0,   7,  5,  10,  3,   7};
      vecs[3] = '{100,127, 999, -1, 999, 110, 1, 0, 105, 11, 110,  5, 105};
      vecs[4] = '{ 20, 40, 999, -1,  30, 999, 1, 0,  24, 10,  30,  6,  24};
      vecs[5] = '{  0,  3, 999, -1, 999, 999, 1, 0,   1,  4,   4,  3,   1};
      vecs[6] = '{120,127, 999, -1, 999, 999, 1, 0, 123,  8, 127,  4, 123};
      vecs[7] = '{ 50, 50, 999, -1, 999, 999, 1, 0,  50,  1,  51,  1,  50};

      ARST_N           = 1'b0;
      TRAIN_START      = 1'b0;
      EXPECTED_PATTERN = 8'h3C;
      repeat (3) @(negedge FAB_CLK);
      chk("reset_outputs", outs_vec(), 0);
      ARST_N = 1'b1;
      @(negedge FAB_CLK);
      chk("idle_outputs", outs_vec(), 0);

      // Start-to-pulse latency, per-tap cost and DONE timing after the last gap
      set_case(vecs[0]);
      pulse_start();
      chk("load_at_n1", int'(DELAY_LINE_LOAD_0), 1);
      chk("busy_at_n1", int'(TRAIN_BUSY), 1);
      @(negedge FAB_CLK);
      chk("clear_at_n2", int'(EYE_MONITOR_CLEAR_FLAGS_0), 1);
      n = 0;
      do begin
         @(negedge FAB_CLK);
         n++;
      end while (!EYE_MONITOR_CLEAR_FLAGS_0 && n < 100);
      chk("tap_period", n, 28);
      n = 0;
      last_mv = -100;
      while (!TRAIN_DONE && !TRAIN_ERR && n < 20000) begin
         @(negedge FAB_CLK);
         n++;
         if (DELAY_LINE_MOVE_0) last_mv = n;
      end
      chk("done_after_gap", n - last_mv, 2);
      chk("timing_center", int'(CENTER_TAP), 30);

      // Table of sweep scenarios
      for (int i = 0; i < 8; i++) begin
         set_case(vecs[i]);
         EXPECTED_PATTERN = 8'(8'h3C + 8'(i * 37));
         @(negedge FAB_CLK);
         inc0 = n_incs; dec0 = n_decs; ld0 = n_loads; vi0 = n_viol;
         pulse_start();
         wait_end($sformatf("c%0d", i));
         @(negedge FAB_CLK);
         chk($sformatf("c%0d_done", i),   int'(TRAIN_DONE),   vecs[i].exp_done);
         chk($sformatf("c%0d_err", i),    int'(TRAIN_ERR),    vecs[i].exp_err);
         chk($sformatf("c%0d_busy", i),   int'(TRAIN_BUSY),   0);
         chk($sformatf("c%0d_center", i), int'(CENTER_TAP),   vecs[i].exp_center);
         chk($sformatf("c%0d_width", i),  int'(WINDOW_WIDTH), vecs[i].exp_width);
         chk($sformatf("c%0d_incs", i),   n_incs - inc0,      vecs[i].exp_incs);
         chk($sformatf("c%0d_decs", i),   n_decs - dec0,      vecs[i].exp_decs);
         chk($sformatf("c%0d_tap", i),    model_tap,          vecs[i].exp_tap);
         chk($sformatf("c%0d_loads", i),  n_loads - ld0,      1);
         chk($sformatf("c%0d_proto", i),  n_viol - vi0,      0);
      end

      // Reset in the middle of SAMPLE, then a clean restart with a stray start while busy
      set_case(vecs[0]);
      EXPECTED_PATTERN = 8'h96;
      pulse_start();
      repeat (15) @(negedge FAB_CLK);
      ARST_N = 1'b0;
      #1;
      chk("arst_immediate", outs_vec(), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge FAB_CLK);
         chk($sformatf("arst_hold%0d", k), outs_vec(), 0);
      end
      ARST_N = 1'b1;
      @(negedge FAB_CLK);
      chk("arst_idle", outs_vec(), 0);
      inc0 = n_incs; dec0 = n_decs; ld0 = n_loads; vi0 = n_viol;
      pulse_start();
      chk("rst_restart_load", int'(DELAY_LINE_LOAD_0), 1);
      repeat (50) @(negedge FAB_CLK);
      pulse_start();
      chk("busy_start_noload", int'(DELAY_LINE_LOAD_0), 0);
      wait_end("rst");
      @(negedge FAB_CLK);
      chk("rst_done",   int'(TRAIN_DONE),   1);
      chk("rst_center", int'(CENTER_TAP),   30);
      chk("rst_width",  int'(WINDOW_WIDTH), 21);
      chk("rst_incs",   n_incs - inc0,      41);
      chk("rst_decs",   n_decs - dec0,      11);
      chk("rst_tap",    model_tap,          30);
      chk("rst_loads",  n_loads - ld0,      1);
      chk("rst_proto",  n_viol - vi0,       0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
